// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
//   Shared types for the MIPS CPU test infrastructure.
//   MTC0Code : code written by test software through MTC0 to report progress.
//   MonState : state of the test monitor that observes those writes.
//   Helper   : is_reportable() tells whether a code has any effect on a run.
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      MTC0_NOOP = 2'd0,
      MTC0_PASS = 2'd1,
      MTC0_FAIL = 2'd2,
      MTC0_DONE = 2'd3
   } MTC0Code;

   typedef enum logic [1:0] {
      MON_RUN     = 2'd0,
      MON_DONE    = 2'd1,
      MON_TIMEOUT = 2'd2
   } MonState;

   // Width of the watchdog cycle counter; matches the TIMEOUT_CYCLES parameter.
   localparam int unsigned WDOG_W = 32;

   // NOOP writes are pure padding from the CPU side: never queued, never
   // counted, and they do not count as activity for the watchdog.
   function automatic logic is_reportable(input MTC0Code code);
      return (code != MTC0_NOOP);
   endfunction

endpackage

// File: rtl/mtc0_evt_fifo.sv
// -----------------------------------------------------------------------------
// mtc0_evt_fifo
//   Small first-word-fall-through queue of MTC0Code events for the host.
//   Storage is registered; the head entry is visible combinationally while
//   the queue is non-empty, and reads as MTC0_NOOP while empty.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset (queue empty)
//   flush        : synchronous empty, wins over push/pop in the same cycle
//   push         : write push_code at the tail (ignored when full)
//   push_code    : code to enqueue
//   pop          : drop the head entry (ignored when empty)
//   head_code    : current head entry, MTC0_NOOP when empty
//   empty, full  : occupancy flags from the pointer extra bit
// -----------------------------------------------------------------------------
module mtc0_evt_fifo
   import mips_cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic    clk,
   input  logic    rst,
   input  logic    flush,
   input  logic    push,
   input  MTC0Code push_code,
   input  logic    pop,
   output MTC0Code head_code,
   output logic    empty,
   output logic    full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   MTC0Code     mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;

   // Pointers carry one extra bit so that equal low bits can be told apart
   // as empty (extra bits equal) or full (extra bits differ).
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   assign head_code = empty ? MTC0_NOOP : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Payload storage needs no reset: it is only read while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_code;
   end

endmodule

// File: rtl/mtc0_test_monitor.sv
// -----------------------------------------------------------------------------
// mtc0_test_monitor
//   Watches PASS/FAIL/DONE reports written by test software through MTC0,
//   counts them, forwards them to the host through a small event queue and
//   declares a timeout when the CPU goes quiet for too long.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. valid may be raised at any time; the payload
//   must stay stable while valid is high and ready is low. mtc0_ready does not
//   depend on mtc0_valid, and evt_valid does not depend on evt_ready.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   clear                  : synchronous restart of a run; drops a same-cycle event
//   mtc0_valid/code/ready  : CPU report channel (in)
//   evt_valid/code/ready   : host event channel (out, first-word-fall-through)
//   pass_count, fail_count : saturating totals of accepted PASS / FAIL
//   state                  : FSM state, exported for observation
//   test_failed            : any FAIL seen, or watchdog fired
// -----------------------------------------------------------------------------
module mtc0_test_monitor
   import mips_cpu_pkg::*;
#(
   parameter int unsigned       CNT_W          = 16,
   parameter int unsigned       FIFO_DEPTH     = 4,
   parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 32'd1_000_000
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             mtc0_valid,
   input  MTC0Code          mtc0_code,
   output logic             mtc0_ready,
   output logic             evt_valid,
   output MTC0Code          evt_code,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output MonState          state,
   output logic             test_failed
);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [WDOG_W-1:0] WD_ONE   = WDOG_W'(1);
   localparam logic [WDOG_W-1:0] WD_LAST  = TIMEOUT_CYCLES - WD_ONE;
   localparam logic              WD_ARMED = (TIMEOUT_CYCLES != '0);

   MonState           state_q, state_d;
   logic [CNT_W-1:0]  pass_q, pass_d;
   logic [CNT_W-1:0]  fail_q, fail_d;
   logic [WDOG_W-1:0] wd_q, wd_d;
   // A timeout DONE that could not be queued yet because the FIFO was full.
   logic              pend_q, pend_d;

   logic              accept;
   logic              reportable;
   logic              fifo_push;
   MTC0Code           fifo_code;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;

   // ---------------------------------------------------------------------------
   // Event queue towards the host
   // ---------------------------------------------------------------------------
   mtc0_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .push      (fifo_push),
      .push_code (fifo_code),
      .pop       (fifo_pop),
      .head_code (evt_code),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign evt_valid = !fifo_empty;
   assign fifo_pop  = evt_valid && evt_ready;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MON_RUN;
         pass_q  <= '0;
         fail_q  <= '0;
         wd_q    <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         wd_q    <= wd_d;
         pend_q  <= pend_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state, counters, watchdog and queue writes
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      wd_d      = wd_q;
      pend_d    = pend_q;
      fifo_push = 1'b0;
      fifo_code = MTC0_NOOP;

      // Once the run has ended, reports are swallowed so the CPU never stalls.
      mtc0_ready = (state_q == MON_RUN) ? !fifo_full : 1'b1;
      accept     = mtc0_valid && mtc0_ready;
      reportable = accept && is_reportable(mtc0_code);

      if (clear) begin
         // The FIFO is flushed by the same signal; any event this cycle is lost.
         state_d = MON_RUN;
         pass_d  = '0;
         fail_d  = '0;
         wd_d    = '0;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            MON_RUN: begin
               if (reportable) begin
                  // ready is low while full, so this push always lands.
                  wd_d      = '0;
                  fifo_push = 1'b1;
                  fifo_code = mtc0_code;
                  case (mtc0_code)
                     MTC0_PASS: if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
                     MTC0_FAIL: if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
                     MTC0_DONE: state_d = MON_DONE;
                     default:   ;
                  endcase
               end else if (WD_ARMED && (wd_q == WD_LAST)) begin
                  state_d = MON_TIMEOUT;
                  if (fifo_full) begin
                     pend_d = 1'b1;
                  end else begin
                     fifo_push = 1'b1;
                     fifo_code = MTC0_DONE;
                  end
               end else if (WD_ARMED) begin
                  wd_d = wd_q + WD_ONE;
               end
            end

            MON_TIMEOUT: begin
               // Deferred end-of-run marker goes in as soon as a slot frees up.
               if (pend_q && !fifo_full) begin
                  fifo_push = 1'b1;
                  fifo_code = MTC0_DONE;
                  pend_d    = 1'b0;
               end
            end

            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pass_count  = pass_q;
   assign fail_count  = fail_q;
   assign state       = state_q;
   assign test_failed = (fail_q != '0) || (state_q == MON_TIMEOUT);

endmodule
